aes_block_packer: RTL
=====================

AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CLKS, default 86800, meaning the number of idle clocks after which a partial block is discarded (0 disables timeout).
REQ-002 The block SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port data_in  input  8  received byte, driven by uart_rx data_out.
REQ-005 The block SHALL have port data_in_valid  input  1  one-cycle strobe qualifying data_in, driven by uart_rx data_out_done.
REQ-006 The block SHALL have port block_out  output  128  assembled 16-byte AES block.
REQ-007 The block SHALL have port block_valid  output  1  block_out holds a complete block.
REQ-008 The block SHALL have port block_ready  input  1  consumer accepts block_out when high with block_valid.
REQ-009 The block SHALL have port byte_count  output  4  number of bytes held in the partial block (0-15).
REQ-010 The block SHALL have port overrun  output  1  one-cycle pulse: completed block discarded because output register busy.
REQ-011 The block SHALL have port timeout  output  1  one-cycle pulse: partial block discarded after inter-byte timeout.

Function
REQ-012 The block SHALL hold two 128-bit stores: an assembly register and the output register driving block_out.
REQ-013 Each cycle with data_in_valid high, the block SHALL write data_in into the assembly register at byte lane byte_count and increment byte_count.
REQ-014 Byte order: the first received byte SHALL appear at block_out[127:120]; the 16th at block_out[7:0].
REQ-015 On the 16th byte (byte_count=15 and data_in_valid), byte_count SHALL wrap to 0 and the completed block SHALL transfer to the output register if it is free.
REQ-016 The output register is free when block_valid is low, or block_valid and block_ready are both high in the same cycle.
REQ-017 Latency: block_valid SHALL rise on the clock edge that samples the 16th data_in_valid; block_out SHALL be stable while block_valid is high.
REQ-018 block_valid SHALL clear on the edge where block_valid and block_ready are both high, unless a new block transfers on that same edge, in which case block_valid stays high and block_out updates.
REQ-019 If the 16th byte completes while the output register is not free, the completed block SHALL be dropped, byte_count SHALL wrap to 0, block_out/block_valid SHALL be unchanged, and overrun SHALL pulse for one cycle.
REQ-020 Assembly SHALL continue independently of block_valid; block_ready SHALL never stall byte acceptance.
REQ-021 An idle counter SHALL reset on every data_in_valid and increment every cycle byte_count is nonzero without data_in_valid.
REQ-022 When the idle counter reaches TIMEOUT_CLKS with byte_count nonzero, byte_count SHALL clear to 0, the idle counter SHALL clear, and timeout SHALL pulse for one cycle.
REQ-023 If data_in_valid coincides with the timeout cycle, the byte SHALL be accepted normally and no timeout SHALL occur.
REQ-024 When byte_count is 0 the idle counter SHALL hold at 0; with TIMEOUT_CLKS=0 timeout SHALL never fire.
REQ-025 Stale bytes in the assembly register after timeout or overrun SHALL never reach block_out; every lane is overwritten before the next transfer.
REQ-026 The block SHALL keep these states: EMPTY (byte_count=0), FILLING (1-15), with output register sub-state IDLE/VALID tracked separately.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously clear block_out to 128'h0, block_valid, overrun, timeout, byte_count and the idle counter to 0.
REQ-028 Reset asserted mid-block SHALL discard all partial and pending data; after release, the first byte SHALL be treated as byte 0.
REQ-029 Release of rst_n SHALL be synchronised internally; no output SHALL change in the first cycle after release unless data_in_valid is high.

Verification
REQ-030 Send bytes 00..0F with block_ready=1 -> block_valid high one cycle, block_out=000102030405060708090A0B0C0D0E0F, no overrun.
REQ-031 block_ready=0, send 32 bytes 00..1F -> block_out stays 00..0F, overrun pulses once on 32nd byte, byte_count=0.
REQ-032 block_ready=0, send 00..0F, then raise block_ready on the same cycle as 16th byte of 10..1F -> block_valid stays high, block_out=101112...1F, no overrun.
REQ-033 TIMEOUT_CLKS=100, send 5 bytes then idle 100 clocks -> timeout pulse, byte_count=0; next 16 bytes AA..B9 form block_out=AAAB...B9.
REQ-034 Send 7 bytes, assert rst_n low for 3 cycles, release, send 00..0F -> block_out=000102...0F, no overrun/timeout.
REQ-035 TIMEOUT_CLKS=100, byte arrives exactly on idle count 100 -> no timeout pulse, byte_count increments.

Source files
------------

// File: rtl/aes_block_packer.sv
// Packs a stream of received bytes into 128-bit AES blocks, first byte in the MSB lane.
// A partial block is dropped after TIMEOUT_CLKS idle clocks; completed blocks are dropped if the output is still held.
module aes_block_packer #(
  parameter int unsigned TIMEOUT_CLKS = 86800
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   data_in,
  input  logic         data_in_valid,
  output logic [127:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [3:0]   byte_count,
  output logic         overrun,
  output logic         timeout
);

  localparam int DATA_W = 8;
  localparam int IDLE_W = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CLKS - 1);

  typedef enum logic { FILL_EMPTY, FILL_FILLING } fill_state_t;
  typedef enum logic { OUT_IDLE, OUT_VALID } out_state_t;

  fill_state_t       fill_st;
  out_state_t        out_st;
  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic [IDLE_W-1:0] idle_cnt;
  logic [6:0]        lane_lsb;
  logic              out_free;

  // Lanes 0..14 only; the 16th byte goes straight from data_in into the output register.
  logic [119:0]      asm_p0;

  // Reset asserts immediately but releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n   = rst_sync[1];
  assign block_valid = (out_st == OUT_VALID);
  assign out_free    = (out_st == OUT_IDLE) || block_ready;
  assign lane_lsb    = {4'd14 - byte_count, 3'b000};

  always_ff @(posedge clk) begin
    if (data_in_valid && byte_count != 4'd15)
      asm_p0[lane_lsb +: DATA_W] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      fill_st    <= FILL_EMPTY;
      out_st     <= OUT_IDLE;
      block_out  <= 128'h0;
      byte_count <= 4'd0;
      idle_cnt   <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      if (out_st == OUT_VALID && block_ready)
        out_st <= OUT_IDLE;

      if (data_in_valid) begin
        idle_cnt <= '0;
        if (byte_count == 4'd15) begin
          byte_count <= 4'd0;
          fill_st    <= FILL_EMPTY;
          if (out_free) begin
            block_out <= {asm_p0, data_in};
            out_st    <= OUT_VALID;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          byte_count <= byte_count + 4'd1;
          fill_st    <= FILL_FILLING;
        end
      end else if (fill_st == FILL_FILLING && TIMEOUT_CLKS != 0) begin
        // The idle clock that would bring the count to TIMEOUT_CLKS discards the partial block.
        if (idle_cnt == IDLE_LAST) begin
          timeout    <= 1'b1;
          byte_count <= 4'd0;
          idle_cnt   <= '0;
          fill_st    <= FILL_EMPTY;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule
